isb_prefetch_buffer: RTL and testbench

Stream buffer directly downstream of the ISB predictor. It accepts predicted prefetch addresses on `pf_v`/`pf_addr`, drops duplicates, and holds accepted addresses in a small ordered queue. It issues them to memory over a valid/ready request channel and tracks their fills. Demand accesses are checked against the queue; a hit retires the matching entry and every older entry (stream skip).

---
 rtl/isb_pkg.sv | 19 +
 rtl/pf_cam.sv | 22 ++
 rtl/isb_prefetch_buffer.sv | 154 +++++++++++++++
 tb/tb_isb_prefetch_buffer.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/isb_pkg.sv
// Shared types for the ISB prefetch stream buffer: entry lifecycle states and
// the default address width matching the ISB predictor.
package isb_pkg;

  localparam int ADDR_W = 16;

  typedef enum logic [1:0] {
    FREE    = 2'd0,
    PENDING = 2'd1,
    ISSUED  = 2'd2,
    READY   = 2'd3
  } entry_state_e;

  typedef struct packed {
    entry_state_e        state;
    logic [ADDR_W-1:0]   addr;
  } entry_t;

endpackage

// File: rtl/pf_cam.sv
// DEPTH-way parallel address compare against a qualified set of entries.
// Produces a one-hot match vector (given unique qualified addresses) and a hit bit.
module pf_cam #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 16
) (
  input  logic [ADDR_W-1:0]             key,
  input  logic [DEPTH-1:0][ADDR_W-1:0]  entry_addr,
  input  logic [DEPTH-1:0]              qual,
  output logic [DEPTH-1:0]              match,
  output logic                          hit
);

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      match[i] = qual[i] && (entry_addr[i] == key);
    end
  end

  assign hit = |match;

endmodule

// File: rtl/isb_prefetch_buffer.sv
// Ordered prefetch stream buffer behind the ISB predictor: dedups and queues
// predicted addresses, issues them to memory, tracks fills, retires on demand hits.
module isb_prefetch_buffer
  import isb_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = isb_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pf_v,
  input  logic [ADDR_W-1:0] pf_addr,
  input  logic              dmd_v,
  input  logic [ADDR_W-1:0] dmd_addr,
  output logic              mem_req_v,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_req_ready,
  input  logic              mem_fill_v,
  input  logic [ADDR_W-1:0] mem_fill_addr,
  output logic              dmd_hit,
  output logic              dmd_hit_ready,
  output logic [7:0]        drop_cnt
);

  localparam int IW = $clog2(DEPTH);
  localparam logic [IW:0] FULL = (IW+1)'(DEPTH);

  typedef logic [IW-1:0] idx_t;

  entry_state_e                 state_q [DEPTH];
  entry_state_e                 state_d [DEPTH];
  logic [DEPTH-1:0][ADDR_W-1:0] addr_q, addr_d;
  idx_t                         head_q, head_d, tail_q, tail_d, iss_q, iss_d;
  logic [IW:0]                  count_q, count_d;
  logic [7:0]                   drop_q, drop_d;
  logic                         dmd_hit_d, dmd_hit_ready_d;

  logic [DEPTH-1:0] live_m, issued_m;
  logic [DEPTH-1:0] dup_match, dmd_match, fill_match, popped;
  logic             dup_hit, dmd_hit_c, fill_hit;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      live_m[i]   = (state_q[i] != FREE);
      issued_m[i] = (state_q[i] == ISSUED);
    end
  end

  // All three lookups see pre-cycle contents only.
  pf_cam #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_dup_cam (
    .key(pf_addr), .entry_addr(addr_q), .qual(live_m), .match(dup_match), .hit(dup_hit)
  );
  pf_cam #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_dmd_cam (
    .key(dmd_addr), .entry_addr(addr_q), .qual(live_m), .match(dmd_match), .hit(dmd_hit_c)
  );
  pf_cam #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_fill_cam (
    .key(mem_fill_addr), .entry_addr(addr_q), .qual(issued_m), .match(fill_match), .hit(fill_hit)
  );

  logic        pop, alloc, full_drop, issue, iss_popped;
  idx_t        dmd_idx, dmd_k, new_head;
  logic [IW:0] pop_n, iss_pos;

  assign mem_req_v    = (state_q[iss_q] == PENDING);
  assign mem_req_addr = addr_q[iss_q];

  assign pop       = dmd_v && dmd_hit_c;
  assign alloc     = pf_v && !dup_hit && (count_q != FULL);
  assign full_drop = pf_v && !dup_hit && (count_q == FULL);
  assign issue     = mem_req_v && mem_req_ready;
  assign dmd_k     = dmd_idx - head_q;
  assign pop_n     = {1'b0, dmd_k} + 1'b1;
  assign new_head  = head_q + dmd_k + 1'b1;

  // iss == head is ambiguous when the queue is full and fully issued; the
  // head entry's state tells "next to issue" apart from "past the tail".
  assign iss_pos = (iss_q == head_q && count_q != '0 && state_q[iss_q] != PENDING)
                   ? count_q : {1'b0, idx_t'(iss_q - head_q)};
  assign iss_popped = pop && (iss_pos <= {1'b0, dmd_k});

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    dmd_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      popped[i] = pop && (idx_t'(idx_t'(i) - head_q) <= dmd_k);
      if (dmd_match[i]) dmd_idx = idx_t'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (mem_fill_v && fill_match[i]) state_d[i] = READY;
    end
    if (issue) state_d[iss_q] = ISSUED;
    if (alloc) begin
      state_d[tail_q] = PENDING;
      addr_d[tail_q]  = pf_addr;
    end
    // Retirement overrides fill and issue on the same entry.
    for (int i = 0; i < DEPTH; i++) begin
      if (popped[i]) state_d[i] = FREE;
    end

    head_d  = pop ? new_head : head_q;
    tail_d  = alloc ? tail_q + 1'b1 : tail_q;
    count_d = count_q + {{IW{1'b0}}, alloc} - (pop ? pop_n : '0);
    if (iss_popped)  iss_d = new_head;
    else if (issue)  iss_d = iss_q + 1'b1;
    else             iss_d = iss_q;

    drop_d = (full_drop && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;

    dmd_hit_d       = pop;
    dmd_hit_ready_d = pop && (state_q[dmd_idx] == READY);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) state_q[i] <= FREE;
      head_q        <= '0;
      tail_q        <= '0;
      iss_q         <= '0;
      count_q       <= '0;
      drop_q        <= '0;
      dmd_hit       <= 1'b0;
      dmd_hit_ready <= 1'b0;
    end else begin
      state_q       <= state_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      iss_q         <= iss_d;
      count_q       <= count_d;
      drop_q        <= drop_d;
      dmd_hit       <= dmd_hit_d;
      dmd_hit_ready <= dmd_hit_ready_d;
    end
  end

  // NOTE: the address array is not reset; an address is only ever observed
  // through an entry whose state is non-FREE, and state is reset.
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
  end

  assign drop_cnt = drop_q;

  logic unused_fill_hit;
  assign unused_fill_hit = fill_hit;

endmodule

// File: tb/tb_isb_prefetch_buffer.sv
// Directed bench for isb_prefetch_buffer: request and demand-response scoreboards
// checked with immediate assertions, plus spot checks of occupancy and drop count.
module tb_isb_prefetch_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        pf_v, dmd_v, mem_req_ready, mem_fill_v;
  logic [15:0] pf_addr, dmd_addr, mem_fill_addr;
  logic        mem_req_v, dmd_hit, dmd_hit_ready;
  logic [15:0] mem_req_addr;
  logic [7:0]  drop_cnt;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_req [$];
  logic [1:0]  exp_dmd [$];

  always #5 clk = ~clk;

  isb_prefetch_buffer #(.DEPTH(4), .ADDR_W(16)) dut (
    .clk(clk), .reset(reset),
    .pf_v(pf_v), .pf_addr(pf_addr),
    .dmd_v(dmd_v), .dmd_addr(dmd_addr),
    .mem_req_v(mem_req_v), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
    .mem_fill_v(mem_fill_v), .mem_fill_addr(mem_fill_addr),
    .dmd_hit(dmd_hit), .dmd_hit_ready(dmd_hit_ready), .drop_cnt(drop_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: record a request handshake and pending demand, cross the edge,
  // then score both against the queues and release the pulse inputs.
  task automatic tick();
    logic        hs;
    logic [15:0] hs_addr;
    logic        dmd_pend;
    logic [15:0] e;
    logic [1:0]  d;
    hs       = !reset && mem_req_v && mem_req_ready;
    hs_addr  = mem_req_addr;
    dmd_pend = !reset && dmd_v;
    @(posedge clk);
    #1;
    if (hs) begin
      if (exp_req.size() == 0) check("req_unexpected", 32'(hs_addr), 32'hFFFF_FFFF);
      else begin
        e = exp_req.pop_front();
        check("req_addr", 32'(hs_addr), 32'(e));
      end
    end
    if (dmd_pend) begin
      if (exp_dmd.size() == 0) check("dmd_unexpected", 32'd1, 32'd0);
      else begin
        d = exp_dmd.pop_front();
        check("dmd_hit/ready", {30'd0, dmd_hit, dmd_hit_ready}, {30'd0, d});
      end
    end else begin
      check("dmd_hit_idle", 32'(dmd_hit), 32'd0);
    end
    pf_v       = 1'b0;
    dmd_v      = 1'b0;
    mem_fill_v = 1'b0;
  endtask

  task automatic prefetch(input logic [15:0] a, input bit accepted);
    pf_v = 1'b1; pf_addr = a;
    if (accepted) exp_req.push_back(a);
  endtask

  task automatic demand(input logic [15:0] a, input logic [1:0] exp);
    dmd_v = 1'b1; dmd_addr = a;
    exp_dmd.push_back(exp);
  endtask

  task automatic fill(input logic [15:0] a);
    mem_fill_v = 1'b1; mem_fill_addr = a;
  endtask

  initial begin
    reset = 1'b1; pf_v = 1'b0; dmd_v = 1'b0; mem_fill_v = 1'b0; mem_req_ready = 1'b0;
    pf_addr = '0; dmd_addr = '0; mem_fill_addr = '0;
    #1;
    tick(); tick();
    reset = 1'b0;
    check("rst_req_v", 32'(mem_req_v), 32'd0);
    check("rst_drop", 32'(drop_cnt), 32'd0);
    check("rst_count", 32'(dut.count_q), 32'd0);

    // Back-to-back issue with memory always ready.
    mem_req_ready = 1'b1;
    prefetch(16'h0100, 1); tick();
    check("first_req_v", 32'(mem_req_v), 32'd1);
    check("first_req_addr", 32'(mem_req_addr), 32'h0100);
    prefetch(16'h0104, 1); tick();
    check("second_req_addr", 32'(mem_req_addr), 32'h0104);
    tick();
    check("drained_req_v", 32'(mem_req_v), 32'd0);

    // Fill then demand: hit on a READY entry retires one.
    fill(16'h0100); tick();
    demand(16'h0100, 2'b11); tick();
    check("fill_dmd_count", 32'(dut.count_q), 32'd1);

    reset = 1'b1; exp_req.delete(); tick(); reset = 1'b0;
    mem_req_ready = 1'b0;

    // Duplicate filter and full drop with memory stalled.
    prefetch(16'h0200, 1); tick();
    prefetch(16'h0200, 0); tick();
    check("dup_count", 32'(dut.count_q), 32'd1);
    prefetch(16'h0300, 1); tick();
    prefetch(16'h0304, 1); tick();
    prefetch(16'h0308, 1); tick();
    prefetch(16'h030C, 0); tick();
    check("full_drop_cnt", 32'(drop_cnt), 32'd1);
    check("full_count", 32'(dut.count_q), 32'd4);
    check("held_req_v", 32'(mem_req_v), 32'd1);
    check("held_req_addr", 32'(mem_req_addr), 32'h0200);

    // Issue A, then a demand on C skips A, B, C; iss jumps to D.
    mem_req_ready = 1'b1; tick(); mem_req_ready = 1'b0;
    check("iss_at_b", 32'(mem_req_addr), 32'h0300);
    demand(16'h0304, 2'b10);
    void'(exp_req.pop_front()); void'(exp_req.pop_front());
    tick();
    check("skip_count", 32'(dut.count_q), 32'd1);
    check("skip_head", 32'(dut.head_q), 32'd3);
    check("skip_req_addr", 32'(mem_req_addr), 32'h0308);

    // Refill to full; a same-cycle head pop does not make room.
    prefetch(16'h0400, 1); tick();
    prefetch(16'h0404, 1); tick();
    prefetch(16'h0408, 1); tick();
    check("refull_count", 32'(dut.count_q), 32'd4);
    demand(16'h0308, 2'b10); prefetch(16'h0500, 0);
    void'(exp_req.pop_front());
    tick();
    check("pop_full_drop", 32'(drop_cnt), 32'd2);
    check("pop_full_count", 32'(dut.count_q), 32'd3);
    check("pop_full_req", 32'(mem_req_addr), 32'h0400);

    // Prefetch equal to an entry popped this cycle is still a duplicate.
    demand(16'h0400, 2'b10); prefetch(16'h0400, 0);
    void'(exp_req.pop_front());
    tick();
    check("dup_pop_count", 32'(dut.count_q), 32'd2);
    check("dup_pop_drop", 32'(drop_cnt), 32'd2);

    mem_req_ready = 1'b1; tick(); tick(); mem_req_ready = 1'b0;
    check("issued_all_v", 32'(mem_req_v), 32'd0);
    check("req_sb_empty", 32'(exp_req.size()), 32'd0);

    // Same-cycle fill and demand report the pre-cycle (not ready) state.
    fill(16'h0404); demand(16'h0404, 2'b10); tick();
    check("fill_dmd_same_count", 32'(dut.count_q), 32'd1);
    demand(16'h0404, 2'b00); tick();
    fill(16'h0408); tick();
    demand(16'h0408, 2'b11); tick();
    check("empty_count", 32'(dut.count_q), 32'd0);

    // Reset in the middle of issuing three entries.
    mem_req_ready = 1'b1;
    prefetch(16'h0600, 1); tick();
    prefetch(16'h0604, 1); tick();
    prefetch(16'h0608, 1); tick();
    check("pre_rst_req_v", 32'(mem_req_v), 32'd1);
    reset = 1'b1; exp_req.delete(); tick(); reset = 1'b0;
    mem_req_ready = 1'b0;
    check("mid_rst_req_v", 32'(mem_req_v), 32'd0);
    check("mid_rst_count", 32'(dut.count_q), 32'd0);
    check("mid_rst_drop", 32'(drop_cnt), 32'd0);
    fill(16'h0600); tick();
    demand(16'h0600, 2'b00); tick();
    check("post_rst_req_v", 32'(mem_req_v), 32'd0);
    check("dmd_sb_empty", 32'(exp_dmd.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
